i2s_rx_deserializer: RTL and testbench

Deserializes the PCM1808 serial output (DOUT) into 24-bit stereo sample pairs. It runs entirely on `clk_100m` and oversamples the externally generated `bck`/`lrck` clocks rather than clocking on them. It sits directly downstream of the I2S clock generator and upstream of the FFT input buffer, delivering one left/right pair per 48 kHz frame over a valid/ready handshake.

---
 rtl/i2s_pkg.sv | 11 +
 rtl/i2s_rx_deserializer_if.sv | 12 +
 rtl/i2s_sync_edge.sv | 14 +
 rtl/i2s_rx_deserializer.sv | 84 ++++++++
 tb/tb_i2s_rx_deserializer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S sample widths, frame geometry and types
package i2s_pkg;
  localparam int SAMPLE_W = 24;
  localparam int BCK_PER_HALF = 32;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;
  typedef enum logic [1:0] {SY_IDLE, SY_HUNT, SY_LOCK} sync_e;
endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// i2s_rx_deserializer_if: stereo sample handshake toward the FFT buffer
interface i2s_rx_deserializer_if;
  import i2s_pkg::*;
  sample_t sample_l;
  sample_t sample_r;
  logic sample_valid;
  logic sample_ready;
  logic overrun;
  logic frame_err;
  modport master (output sample_l, sample_r, sample_valid, overrun, frame_err, input sample_ready);
  modport slave (input sample_l, sample_r, sample_valid, overrun, frame_err, output sample_ready);
endinterface

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: 2-FF synchronizer plus rising-edge detect on the synchronized level
module i2s_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [2:0] sh;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else sh <= {sh[1:0], d};
  end
  assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: oversampled PCM1808 DOUT capture into validated 24-bit stereo pairs
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter bit FMT_I2S = 1'b1
) (
  input  logic clk_100m,
  input  logic rst_n,
  input  logic bck,
  input  logic lrck,
  input  logic sdata,
  i2s_rx_deserializer_if.master rx
);
  localparam logic [5:0] LAST_BIT = 6'(BCK_PER_HALF - 1);
  localparam logic [5:0] WIN_LO = 6'(FMT_I2S);
  localparam logic [5:0] WIN_LEN = 6'(SAMPLE_W);
  logic bck_rise, lrck_s, sdata_s, lrck_prev, left_ok;
  logic valid_q, ovr_q, ferr_q;
  logic boundary, synced, in_win, commit, bad, emit;
  logic [1:0] lrck_ff, sdata_ff;
  logic [5:0] bit_cnt, cnt_nxt;
  sample_t sh_l, sh_r, left_hold;
  stereo_t out_q;
  sync_e st, st_nxt;
  i2s_sync_edge u_bck (.clk(clk_100m), .rst_n(rst_n), .d(bck), .rise(bck_rise));
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      lrck_ff <= '0;
      sdata_ff <= '0;
    end else begin
      lrck_ff <= {lrck_ff[0], lrck};
      sdata_ff <= {sdata_ff[0], sdata};
    end
  end
  assign lrck_s = lrck_ff[1];
  assign sdata_s = sdata_ff[1];
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) st <= SY_IDLE;
    else st <= st_nxt;
  end
  // the first rise after reset only primes lrck_prev so a stale level is never seen as a boundary
  always_comb begin
    boundary = bck_rise && st != SY_IDLE && lrck_s != lrck_prev;
    synced = st == SY_LOCK;
    cnt_nxt = boundary ? '0 : (&bit_cnt ? bit_cnt : bit_cnt + 6'd1);
    in_win = (cnt_nxt - WIN_LO) < WIN_LEN;
    commit = boundary && synced && bit_cnt == LAST_BIT;
    bad = boundary && synced && bit_cnt != LAST_BIT;
    emit = commit && lrck_prev && left_ok;
    st_nxt = !bck_rise ? st : st == SY_IDLE ? SY_HUNT : boundary ? SY_LOCK : st;
  end
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      lrck_prev <= 1'b0;
      sh_l <= '0;
      sh_r <= '0;
      left_hold <= '0;
      left_ok <= 1'b0;
      out_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= bad;
      ovr_q <= emit && valid_q && !rx.sample_ready;
      if (bck_rise) begin
        bit_cnt <= cnt_nxt;
        lrck_prev <= lrck_s;
      end
      if (bck_rise && in_win && !lrck_s) sh_l <= {sh_l[SAMPLE_W-2:0], sdata_s};
      if (bck_rise && in_win && lrck_s) sh_r <= {sh_r[SAMPLE_W-2:0], sdata_s};
      if (commit && !lrck_prev) left_hold <= sh_l;
      left_ok <= (commit && !lrck_prev) ? 1'b1 : (bad || (commit && lrck_prev)) ? 1'b0 : left_ok;
      if (emit) out_q <= {left_hold, sh_r};
      valid_q <= emit || (valid_q && !rx.sample_ready);
    end
  end
  assign rx.sample_l = out_q.l;
  assign rx.sample_r = out_q.r;
  assign rx.sample_valid = valid_q;
  assign rx.overrun = ovr_q;
  assign rx.frame_err = ferr_q;
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb_i2s_rx_deserializer: I2S and left-justified receivers fed by one BFM, checked against a frame-level model
module tb_i2s_rx_deserializer;
  logic clk = 1'b0, rst_n = 1'b0, bck = 1'b0, lrck = 1'b1, sd_i2s = 1'b0, sd_lj = 1'b0, ready = 1'b1;
  int n_chk = 0, n_fail = 0;
  time t_lrise = 0;
  logic [47:0] obs0[$], obs1[$], exp_q[$];
  int ferr_c[2] = '{0, 0}, ovr_c[2] = '{0, 0}, lat_bad[2] = '{0, 0};
  logic v0_d = 1'b0, v1_d = 1'b0;
  bit m_synced = 0, m_left_ok = 0, m_valid = 0, pend = 0;
  logic [23:0] m_left;
  logic [47:0] m_held;
  int e_ferr = 0, e_ovr = 0;
  logic pend_lr;
  logic [23:0] pend_w;
  int pend_n;

  i2s_rx_deserializer_if ifa ();
  i2s_rx_deserializer_if ifb ();
  assign ifa.sample_ready = ready;
  assign ifb.sample_ready = ready;

  i2s_rx_deserializer #(.FMT_I2S(1'b1)) dut_i2s (
    .clk_100m(clk), .rst_n(rst_n), .bck(bck), .lrck(lrck), .sdata(sd_i2s), .rx(ifa));
  i2s_rx_deserializer #(.FMT_I2S(1'b0)) dut_lj (
    .clk_100m(clk), .rst_n(rst_n), .bck(bck), .lrck(lrck), .sdata(sd_lj), .rx(ifb));

  initial begin
    #2;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (ifa.sample_valid && ifa.sample_ready) obs0.push_back({ifa.sample_l, ifa.sample_r});
    if (ifb.sample_valid && ifb.sample_ready) obs1.push_back({ifb.sample_l, ifb.sample_r});
    if (ifa.frame_err) ferr_c[0]++;
    if (ifb.frame_err) ferr_c[1]++;
    if (ifa.overrun) ovr_c[0]++;
    if (ifb.overrun) ovr_c[1]++;
    if (ifa.sample_valid && !v0_d && ($time - t_lrise < 32 || $time - t_lrise > 42)) lat_bad[0]++;
    if (ifb.sample_valid && !v1_d && ($time - t_lrise < 32 || $time - t_lrise > 42)) lat_bad[1]++;
    v0_d = ifa.sample_valid;
    v1_d = ifb.sample_valid;
  end

  task automatic ck(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic emit_pair(input logic [23:0] l, input logic [23:0] r);
    if (ready) exp_q.push_back({l, r});
    else begin
      if (m_valid) e_ovr++;
      m_held = {l, r};
      m_valid = 1;
    end
  endtask

  // a half-frame's fate is decided only when it has ended
  task automatic model_end(input logic lr, input logic [23:0] w, input int n);
    if (!m_synced) m_synced = 1;
    else if (n != 32) begin
      e_ferr++;
      m_left_ok = 0;
    end else if (!lr) begin
      m_left = w;
      m_left_ok = 1;
    end else if (m_left_ok) begin
      m_left_ok = 0;
      emit_pair(m_left, w);
    end
  endtask

  task automatic set_ready(input logic v);
    ready = v;
    if (v && m_valid) begin
      exp_q.push_back(m_held);
      m_valid = 0;
    end
  endtask

  task automatic send_half(input logic lr, input logic [23:0] w, input int n);
    if (pend) model_end(pend_lr, pend_w, pend_n);
    pend = 1;
    pend_lr = lr;
    pend_w = w;
    pend_n = n;
    for (int k = 0; k < n; k++) begin
      lrck = lr;
      sd_lj = (k < 24) ? w[23-k] : 1'b0;
      sd_i2s = (k >= 1 && k < 25) ? w[24-k] : 1'b0;
      #80 bck = 1'b1;
      if (!lr && k == 0) t_lrise = $time;
      #160 bck = 1'b0;
      #80;
    end
  endtask

  task automatic chk(input string tag);
    ck({tag, "_cnt_i2s"}, 64'(obs0.size()), 64'(exp_q.size()));
    ck({tag, "_cnt_lj"}, 64'(obs1.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs0.size() && i < exp_q.size(); i++) ck({tag, "_pair_i2s"}, 64'(obs0[i]), 64'(exp_q[i]));
    for (int i = 0; i < obs1.size() && i < exp_q.size(); i++) ck({tag, "_pair_lj"}, 64'(obs1[i]), 64'(exp_q[i]));
    for (int d = 0; d < 2; d++) begin
      ck({tag, "_frame_err"}, 64'(ferr_c[d]), 64'(e_ferr));
      ck({tag, "_overrun"}, 64'(ovr_c[d]), 64'(e_ovr));
      ck({tag, "_latency"}, 64'(lat_bad[d]), 64'd0);
    end
    obs0.delete();
    obs1.delete();
    exp_q.delete();
  endtask

  task automatic ck_outs_zero(input string tag);
    ck({tag, "_i2s"}, 64'({ifa.sample_l, ifa.sample_r, ifa.sample_valid, ifa.overrun, ifa.frame_err}), 64'd0);
    ck({tag, "_lj"}, 64'({ifb.sample_l, ifb.sample_r, ifb.sample_valid, ifb.overrun, ifb.frame_err}), 64'd0);
  endtask

  task automatic ck_held(input string tag);
    ck({tag, "_i2s"}, 64'({ifa.sample_valid, ifa.sample_l, ifa.sample_r}), 64'({1'b1, m_held}));
    ck({tag, "_lj"}, 64'({ifb.sample_valid, ifb.sample_l, ifb.sample_r}), 64'({1'b1, m_held}));
  endtask

  initial begin
    #50;
    ck_outs_zero("reset");
    #50 rst_n = 1'b1;
    send_half(1'b1, 24'($urandom), 15);
    send_half(1'b0, 24'h7FFFFF, 32);
    send_half(1'b1, 24'h800000, 32);
    send_half(1'b0, 24'h123456, 32);
    chk("startup_pair");
    send_half(1'b1, 24'hABCDEF, 32);
    for (int i = 0; i < 3; i++) begin
      send_half(1'b0, 24'($urandom), 32);
      chk("random_pair");
      send_half(1'b1, 24'($urandom), 32);
    end
    set_ready(1'b0);
    send_half(1'b0, 24'($urandom), 32);
    ck_held("bp_first");
    send_half(1'b1, 24'($urandom), 32);
    ck_held("bp_stable");
    send_half(1'b0, 24'($urandom), 32);
    ck_held("bp_overwrite");
    send_half(1'b1, 24'($urandom), 32);
    set_ready(1'b1);
    #40;
    ck("bp_release_valid", 64'({ifa.sample_valid, ifb.sample_valid}), 64'd0);
    send_half(1'b0, 24'($urandom), 32);
    chk("backpressure");
    send_half(1'b1, 24'($urandom), 32);
    send_half(1'b0, 24'($urandom), 31);
    send_half(1'b1, 24'($urandom), 32);
    send_half(1'b0, 24'($urandom), 32);
    chk("bad_half");
    send_half(1'b1, 24'($urandom), 32);
    send_half(1'b0, 24'($urandom), 32);
    chk("after_bad");
    set_ready(1'b0);
    send_half(1'b1, 24'($urandom), 32);
    send_half(1'b0, 24'($urandom), 10);
    ck_held("pre_reset");
    rst_n = 1'b0;
    #3;
    ck_outs_zero("mid_reset");
    m_synced = 0;
    m_left_ok = 0;
    m_valid = 0;
    pend = 0;
    #37 rst_n = 1'b1;
    set_ready(1'b1);
    send_half(1'b0, 24'($urandom), 22);
    send_half(1'b1, 24'($urandom), 32);
    send_half(1'b0, 24'($urandom), 32);
    send_half(1'b1, 24'($urandom), 32);
    send_half(1'b0, 24'($urandom), 32);
    chk("post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
